// File: rtl/ifm_rf_pkg.sv
// Shared types and helpers for the ping-pong input-feature-map register file.
package ifm_rf_pkg;

   // Life cycle of one shift-chain bank
   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   // Map a requested chain length onto the legal range 1..maxDepth
   function automatic int unsigned clampLen(input int unsigned rawLen,
                                            input int unsigned maxDepth);
      if (rawLen == 0) begin
         return 1;
      end
      if (rawLen > maxDepth) begin
         return maxDepth;
      end
      return rawLen;
   endfunction

endpackage

// File: rtl/ifm_rf_bank.sv
// One shift-chain bank: element[0] is the tail that receives new data, the
// element at index len-1 is the head tapped for reads. A single counter tracks
// writes while the bank fills and pops while it drains.
module ifm_rf_bank
   import ifm_rf_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_DEPTH  = 27,
   parameter int LEN_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] shift_in,
   input  logic [DATA_WIDTH-1:0] tail_data,
   input  logic [LEN_W-1:0]      len,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] tap,
   output bank_state_e           state,
   output logic                  pass_done
);

   logic [DATA_WIDTH-1:0] chain_q [MAX_DEPTH];
   logic [DATA_WIDTH-1:0] chain_d [MAX_DEPTH];
   logic [LEN_W-1:0]      cnt_q;
   logic [LEN_W-1:0]      cnt_d;
   bank_state_e           state_q;
   bank_state_e           state_d;
   logic [LEN_W-1:0]      tapIdx;

   // Head tap and "the next shift finishes the current fill or drain pass"
   always_comb begin
      tapIdx    = len - LEN_W'(1);
      tap       = chain_q[tapIdx];
      state     = state_q;
      pass_done = (cnt_q == tapIdx);
   end

   // Next-state: clear wins; a FULL bank takes its tail from the drain path
   always_comb begin
      chain_d = chain_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (clear) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            chain_d[i] = '0;
         end
         cnt_d   = '0;
         state_d = BANK_EMPTY;
      end else if (shift_en) begin
         chain_d[0] = (state_q == BANK_FULL) ? tail_data : shift_in;
         for (int i = 1; i < MAX_DEPTH; i++) begin
            chain_d[i] = chain_q[i-1];
         end
         if (pass_done) begin
            cnt_d   = '0;
            state_d = BANK_FULL;
         end else begin
            cnt_d = cnt_q + LEN_W'(1);
            if (state_q == BANK_EMPTY) begin
               state_d = BANK_FILLING;
            end
         end
      end
   end

   // Chain, counter and state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            chain_q[i] <= '0;
         end
         cnt_q   <= '0;
         state_q <= BANK_EMPTY;
      end else begin
         chain_q <= chain_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/ifm_pingpong_rf.sv
// Ping-pong input-feature-map register file: two banks alternate between
// being filled by the write port and drained (or replayed) by the read port.
module ifm_pingpong_rf
   import ifm_rf_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_DEPTH  = 27,
   parameter int LEN_W      = 5,
   parameter int PASS_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic                  recirc,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   input  logic                  rd_en,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_release,
   output logic [1:0]            bank_full,
   output logic [PASS_W-1:0]     pass_cnt
);

   logic                  wrSel_q, wrSel_d;
   logic                  rdSel_q, rdSel_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [PASS_W-1:0]     passCnt_q, passCnt_d;
   logic [DATA_WIDTH-1:0] rdData_q, rdData_d;

   logic [DATA_WIDTH-1:0] tap [2];
   bank_state_e           bankState [2];
   logic                  passDone [2];
   logic                  shiftEn [2];
   logic                  clearBank [2];
   logic [DATA_WIDTH-1:0] tailData [2];

   logic bothEmpty;
   logic wrAccept;
   logic popHit;
   logic relHit;
   logic popPassEnd;
   logic rdDrained;

   // Handshake decode and per-bank steering; FULL blocks writes, so a write
   // and a pop can never land on the same bank
   always_comb begin
      bothEmpty  = (bankState[0] == BANK_EMPTY) && (bankState[1] == BANK_EMPTY);
      wr_ready   = (bankState[wrSel_q] != BANK_FULL);
      rd_valid   = (bankState[rdSel_q] == BANK_FULL);
      wrAccept   = wr_valid && wr_ready;
      popHit     = rd_en && rd_valid;
      relHit     = rd_release && rd_valid;
      popPassEnd = popHit && passDone[rdSel_q];
      rdDrained  = (popPassEnd && !recirc) || relHit;
      for (int b = 0; b < 2; b++) begin
         shiftEn[b]   = (wrAccept && (wrSel_q == 1'(b))) ||
                        (popHit && (rdSel_q == 1'(b)));
         clearBank[b] = rdDrained && (rdSel_q == 1'(b));
         tailData[b]  = recirc ? tap[b] : '0;
      end
      bank_full = {bankState[1] == BANK_FULL, bankState[0] == BANK_FULL};
      rd_data   = rdData_q;
      pass_cnt  = passCnt_q;
   end

   // Next values for selectors, length, pass counter and read register
   always_comb begin
      len_d     = bothEmpty ? LEN_W'(clampLen(32'(cfg_len), MAX_DEPTH)) : len_q;
      wrSel_d   = wrSel_q ^ (wrAccept && passDone[wrSel_q]);
      rdSel_d   = rdSel_q ^ rdDrained;
      rdData_d  = popHit ? tap[rdSel_q] : rdData_q;
      passCnt_d = passCnt_q;
      if (rdDrained) begin
         passCnt_d = '0;
      end else if (popPassEnd && recirc && (passCnt_q != '1)) begin
         passCnt_d = passCnt_q + PASS_W'(1);
      end
   end

   // Top-level control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrSel_q   <= 1'b0;
         rdSel_q   <= 1'b0;
         len_q     <= LEN_W'(1);
         passCnt_q <= '0;
         rdData_q  <= '0;
      end else begin
         wrSel_q   <= wrSel_d;
         rdSel_q   <= rdSel_d;
         len_q     <= len_d;
         passCnt_q <= passCnt_d;
         rdData_q  <= rdData_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : gBank
      ifm_rf_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .MAX_DEPTH  (MAX_DEPTH),
         .LEN_W      (LEN_W)
      ) uBank (
         .clk       (clk),
         .rst_n     (rst_n),
         .shift_en  (shiftEn[g]),
         .shift_in  (wr_data),
         .tail_data (tailData[g]),
         .len       (len_q),
         .clear     (clearBank[g]),
         .tap       (tap[g]),
         .state     (bankState[g]),
         .pass_done (passDone[g])
      );
   end

endmodule

// File: doc/ifm_pingpong_rf.md
Name: ifm_pingpong_rf

Overview:
Parametrised ping-pong input-feature-map register file feeding one systolic-array row. Two shift-chain banks sit behind a valid/ready write port and a pop-style read port.
- Bank selection is automatic, driven by fill and drain state; no external demux/mux control.
- Active chain length is configurable at runtime.
- Optional recirculation mode replays a loaded bank for several filter passes before releasing it.

Parameters:
DATA_WIDTH, 8, element width in bits
MAX_DEPTH, 27, physical shift-chain length per bank
LEN_W, 5, width of cfg_len/count fields (must satisfy 2^LEN_W > MAX_DEPTH)
PASS_W, 4, width of replay pass counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_len  in  LEN_W  active chain length; legal range 1..MAX_DEPTH
recirc  in  1  1 = popped elements re-enter the bank tail (replay mode)
wr_valid  in  1  write element offered
wr_data  in  DATA_WIDTH  write element
wr_ready  out  1  write bank can accept
rd_en  in  1  pop request
rd_valid  out  1  read bank FULL, pop permitted
rd_data  out  DATA_WIDTH  popped element, registered
rd_release  in  1  free the read bank (replay mode)
bank_full  out  2  per-bank FULL flag
pass_cnt  out  PASS_W  completed replay passes on the current read bank

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset asserted at any time, including mid-fill or mid-drain, forces:
  - both banks EMPTY, chains zeroed, counts 0
  - wr_sel=0, rd_sel=0, len_q=1
  - rd_data=0, pass_cnt=0, wr_ready=1, rd_valid=0, bank_full=0
- len_q latches the clamped cfg_len only on cycles when both banks are EMPTY. Clamp: 0 becomes 1; values above MAX_DEPTH become MAX_DEPTH. cfg_len changes at any other time are ignored.
- Per-bank state machine:
  - EMPTY -> FILLING on first accepted write
  - FILLING -> FULL when the write count reaches len_q (len_q=1 goes EMPTY -> FULL in one accept)
  - FULL -> EMPTY on drain completion or release
- Write port:
  - wr_ready = (bank[wr_sel] is EMPTY or FILLING).
  - An accept (wr_valid & wr_ready) shifts wr_data into element[0] of bank[wr_sel]; all other elements shift up by one.
  - On the accept that makes the bank FULL, wr_sel toggles on the same edge.
  - wr_valid while !wr_ready is ignored; the chain holds.
- Read port:
  - rd_valid = bank_full[rd_sel].
  - A pop (rd_en & rd_valid) loads rd_data with element[len_q-1] of bank[rd_sel] on the next edge, so latency is 1 cycle. rd_data holds between pops.
  - The same pop shifts the chain. The new element[0] is the popped value if recirc=1, otherwise 0.
  - Pop order equals write order.
  - rd_en while !rd_valid is ignored.
- Drain completion:
  - recirc=0: after len_q pops the bank goes EMPTY, rd_sel toggles, pass_cnt clears.
  - recirc=1: after each len_q pops pass_cnt increments, saturating at all-ones, and the bank stays FULL with original contents restored.
- Release:
  - rd_release while FULL empties the bank, toggles rd_sel and clears pass_cnt, including when a pop occurs in the same cycle. That pop still delivers its data.
  - rd_release while !rd_valid is ignored.
- Simultaneous events:
  - A write to one bank and a pop from the other in the same cycle are independent.
  - Write and read never target the same bank in the same cycle, because FULL blocks writes.
  - When both banks are FULL, wr_ready=0.
- recirc is sampled per pop. Changing it mid-pass corrupts only that bank's replay contents and does not affect state machine correctness.

Decomposition:
- Package ifm_rf_pkg holds:
  - bank state encoding: EMPTY=2'd0, FILLING=2'd1, FULL=2'd2
  - length-clamp function
- One sub-module, ifm_rf_bank, instantiated twice. It contains the shift chain, a variable tap at len_q-1, a fill/pop counter and the state register. Its inputs are shift_in, shift_en, tail_data, len, clear. Its outputs are tap, state, pass_done.
- The top level holds wr_sel, rd_sel, len_q, pass_cnt and the rd_data register.

Test Plan:
- Basic ping-pong, cfg_len=3, recirc=0: write 1,2,3,4,5,6 back-to-back. Required: wr_ready stays 1; bank_full=2'b11 after the 6th write; pops yield 1,2,3 then 4,5,6 with 1-cycle latency; bank_full returns to 0.
- Backpressure: fill both banks with len=2, then hold wr_valid=1 with data 9. Required: wr_ready=0 and no state change. After 2 pops, wr_ready=1 and 9 lands in bank 0.
- Replay, cfg_len=4, recirc=1, data 10,20,30,40: 12 pops. Required: the sequence 10..40 appears three times; pass_cnt=3; rd_valid stays 1. rd_release then gives rd_valid=0 (bank 1 empty) and pass_cnt=0.
- Clamp: cfg_len=0 gives FULL after 1 write. cfg_len=31 with MAX_DEPTH=27 gives FULL after 27 writes, and the first pop returns the first written element.
- Reset mid-operation: assert rst_n=0 asynchronously during a drain with rd_data=7. Required: rd_data=0, bank_full=0 and wr_ready=1 immediately, with no clock edge needed.
- Ignored inputs: rd_en and rd_release with both banks EMPTY give no rd_data change. cfg_len change while bank 0 is FILLING is not applied until both banks are empty.
